// File: rtl/sobel_window_gen.sv
// Raster-to-3x3 window generator for the sobel stage: two line buffers plus a shifting 3x3 register window.
// Latency: a window leaves one cycle after the stream advance that completes it; a frame flush adds IMG_W+1 cycles.
// Backpressure: in_ready is low only while the frame is flushed. Build option SOBEL_WIN_REPLICATE_EN clamps borders instead of zero-padding them.
module sobel_window_gen #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 512,
   parameter int IMG_H  = 512
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pixel,
   output logic              out_valid,
   output logic [DATA_W-1:0] p0,
   output logic [DATA_W-1:0] p1,
   output logic [DATA_W-1:0] p2,
   output logic [DATA_W-1:0] p3,
   output logic [DATA_W-1:0] p4,
   output logic [DATA_W-1:0] p5,
   output logic [DATA_W-1:0] p6,
   output logic [DATA_W-1:0] p7,
   output logic [DATA_W-1:0] p8
);

   localparam int XW  = $clog2(IMG_W);
   localparam int YW  = $clog2(IMG_H + 1);
   localparam int CYW = $clog2(IMG_H);

   localparam logic [XW-1:0]  X_ONE   = XW'(1);
   localparam logic [XW-1:0]  X_LAST  = XW'(IMG_W - 1);
   localparam logic [YW-1:0]  Y_ONE   = YW'(1);
   localparam logic [YW-1:0]  Y_LAST  = YW'(IMG_H - 1);
   localparam logic [YW-1:0]  Y_END   = YW'(IMG_H);
   localparam logic [CYW-1:0] CY_ONE  = CYW'(1);
   localparam logic [CYW-1:0] CY_LAST = CYW'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t state_q, state_d;

   // Stream position (sx, sy) addresses the line buffers; (cx, cy) is the centre of the next window out.
   logic [XW-1:0]  sx_q, sx_d;
   logic [YW-1:0]  sy_q, sy_d;
   logic [XW-1:0]  cx_q, cx_d;
   logic [CYW-1:0] cy_q, cy_d;

   logic              adv;     // stream advances this cycle
   logic              prod;    // the advance completes a window
   logic              clr;     // last flush cycle: rewind all counters
   logic [DATA_W-1:0] pix;     // pixel entering the stream (zero while flushing)
   logic [DATA_W-1:0] rd1;     // same column, line y-1
   logic [DATA_W-1:0] rd2;     // same column, line y-2

   logic [DATA_W-1:0] lb1 [IMG_W];
   logic [DATA_W-1:0] lb2 [IMG_W];

   logic [DATA_W-1:0] win_q [9];
   logic [DATA_W-1:0] win_d [9];
   logic [DATA_W-1:0] msk   [9];
   logic [DATA_W-1:0] out_q [9];
   logic              out_valid_q;

   logic at_l, at_r, at_t, at_b;

   // Frame sequencing: decides when the stream advances and when a window is emitted.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b1;
      adv      = 1'b0;
      prod     = 1'b0;
      clr      = 1'b0;
      pix      = in_pixel;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               adv     = 1'b1;
               state_d = FILL;
            end
         end
         FILL: begin
            if (in_valid) begin
               adv = 1'b1;
               // Stream position IMG_W+1 is the first one whose window centre lies in the image.
               if (sx_q == X_ONE && sy_q == Y_ONE) begin
                  prod    = 1'b1;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (in_valid) begin
               adv  = 1'b1;
               prod = 1'b1;
               if (sx_q == X_LAST && sy_q == Y_LAST) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            in_ready = 1'b0;
            adv      = 1'b1;
            prod     = 1'b1;
            pix      = '0;
            if (cx_q == X_LAST && cy_q == CY_LAST) begin
               clr     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of the stream and centre counters.
   always_comb begin
      sx_d = sx_q;
      sy_d = sy_q;
      cx_d = cx_q;
      cy_d = cy_q;
      if (clr) begin
         sx_d = '0;
         sy_d = '0;
         cx_d = '0;
         cy_d = '0;
      end else begin
         if (adv) begin
            if (sx_q == X_LAST) begin
               sx_d = '0;
               if (sy_q != Y_END) begin
                  sy_d = sy_q + Y_ONE;
               end
            end else begin
               sx_d = sx_q + X_ONE;
            end
         end
         if (prod) begin
            if (cx_q == X_LAST) begin
               cx_d = '0;
               cy_d = cy_q + CY_ONE;
            end else begin
               cx_d = cx_q + X_ONE;
            end
         end
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sx_q    <= '0;
         sy_q    <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
      end else begin
         state_q <= state_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
      end
   end

   assign rd1 = lb1[sx_q];
   assign rd2 = lb2[sx_q];

   // Line buffers: the current column is read before it is overwritten, cascading y -> y-1 -> y-2.
   always_ff @(posedge clk) begin
      if (adv) begin
         lb1[sx_q] <= pix;
         lb2[sx_q] <= rd1;
      end
   end

   // Window after this cycle's shift: every row moves one column left and takes its new rightmost pixel.
   always_comb begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = rd2;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = rd1;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix;
   end

   // Shifting window register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= '0;
         end
      end else if (adv) begin
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= win_d[i];
         end
      end
   end

   assign at_l = (cx_q == '0);
   assign at_r = (cx_q == X_LAST);
   assign at_t = (cy_q == '0);
   assign at_b = (cy_q == CY_LAST);

   // Border handling: cells outside the image hold wrapped or stale pixels and are overridden.
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         msk[i] = win_d[i];
      end
`ifdef SOBEL_WIN_REPLICATE_EN
      // Columns clamp first, rows second, so corners take the centre pixel.
      for (int r = 0; r < 3; r++) begin
         if (at_l) msk[3*r]     = msk[3*r + 1];
         if (at_r) msk[3*r + 2] = msk[3*r + 1];
      end
      for (int c = 0; c < 3; c++) begin
         if (at_t) msk[c]     = msk[3 + c];
         if (at_b) msk[6 + c] = msk[3 + c];
      end
`else
      for (int r = 0; r < 3; r++) begin
         if (at_l) msk[3*r]     = '0;
         if (at_r) msk[3*r + 2] = '0;
      end
      for (int c = 0; c < 3; c++) begin
         if (at_t) msk[c]     = '0;
         if (at_b) msk[6 + c] = '0;
      end
`endif
   end

   // Output register: pulses valid per window and holds the last window in between.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            out_q[i] <= '0;
         end
      end else begin
         out_valid_q <= prod;
         if (prod) begin
            for (int i = 0; i < 9; i++) begin
               out_q[i] <= msk[i];
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign p0 = out_q[0];
   assign p1 = out_q[1];
   assign p2 = out_q[2];
   assign p3 = out_q[3];
   assign p4 = out_q[4];
   assign p5 = out_q[5];
   assign p6 = out_q[6];
   assign p7 = out_q[7];
   assign p8 = out_q[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x3 image: randomized frames against an image-level window model.
// Every cycle checks in_ready, out_valid and the held window; fixed frames also check known windows.
// Covers stalls, flush length, back-to-back frames and asynchronous reset mid-frame.
module tb_sobel_window_gen;

   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_pixel = '0;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;

   always #5 clk = ~clk;

   sobel_window_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_pixel (in_pixel),
      .out_valid(out_valid),
      .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4),
      .p5(p5), .p6(p6), .p7(p7), .p8(p8)
   );

   int          n_err = 0;
   int          n_chk = 0;
   logic [7:0]  img [N];
   logic [71:0] got_q [$];

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [71:0] pk(input int a0, input int a1, input int a2,
                                      input int a3, input int a4, input int a5,
                                      input int a6, input int a7, input int a8);
      return {8'(a0), 8'(a1), 8'(a2), 8'(a3), 8'(a4), 8'(a5), 8'(a6), 8'(a7), 8'(a8)};
   endfunction

   // Window centred on raster index c, taken straight from the image with the border rule applied.
   function automatic logic [71:0] ref_win(input int c);
      int          x, y, xx, yy;
      logic [7:0]  v;
      logic [71:0] r;
      x = c % W;
      y = c / W;
      r = '0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            xx = x + dx;
            yy = y + dy;
`ifdef SOBEL_WIN_REPLICATE_EN
            if (xx < 0) xx = 0;
            if (xx > W - 1) xx = W - 1;
            if (yy < 0) yy = 0;
            if (yy > H - 1) yy = H - 1;
            v = img[yy * W + xx];
`else
            if (xx < 0 || xx >= W || yy < 0 || yy >= H) v = '0;
            else v = img[yy * W + xx];
`endif
            r = {r[63:0], v};
         end
      end
      return r;
   endfunction

   // Stream-position model: position s advances on an accept (s < N) or unconditionally while
   // flushing (N <= s <= N+W); advancing position s emits the window centred at s-W-1.
   int          ms = 0;
   logic        pend_vld = 1'b0;
   logic [71:0] exp_p = '0;

   always @(posedge clk or negedge rst_n) begin : model
      int          s;
      logic        v;
      logic [71:0] w;
      if (!rst_n) begin
         ms       <= 0;
         pend_vld <= 1'b0;
         exp_p    <= '0;
      end else begin
         s = ms;
         v = 1'b0;
         w = exp_p;
         if (s >= N || in_valid) begin
            if (s >= W + 1) begin
               v = 1'b1;
               w = ref_win(s - W - 1);
            end
            s = s + 1;
            if (s == N + W + 1) s = 0;
         end
         ms       <= s;
         pend_vld <= v;
         exp_p    <= w;
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      check("in_ready", in_ready, ms < N);
      check("out_valid", out_valid, pend_vld);
      check("window", {p0, p1, p2, p3, p4, p5, p6, p7, p8}, exp_p);
      if (out_valid) got_q.push_back({p0, p1, p2, p3, p4, p5, p6, p7, p8});
   end

   // Called at posedge+1; returns at posedge+1 after the pixel was accepted.
   task automatic push(input logic [7:0] v);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_pixel = v;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) check("push_timeout", 72'd0, 72'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic fill_seq(input int b);
      for (int i = 0; i < N; i++) img[i] = 8'(b + 1 + i);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < N; i++) img[i] = 8'($urandom);
   endtask

   // mode 0: back-to-back, 1: 3-cycle stall after every 2nd pixel, 2: random gaps.
   task automatic run_frame(input int mode, input int npx);
      int cnt;
      got_q.delete();
      for (int i = 0; i < npx; i++) begin
         if (mode == 2 && $urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         end
         push(img[i]);
         if (mode == 1 && i % 2 == 1 && i < npx - 1) begin
            repeat (3) begin @(posedge clk); #1; end
         end
      end
      if (npx == N) begin
         // in_valid toggles randomly during the flush and must be ignored.
         cnt = 0;
         while (!in_ready && cnt < 20) begin
            in_valid = 1'($urandom);
            in_pixel = 8'($urandom);
            @(posedge clk); #1;
            cnt++;
         end
         in_valid = 1'b0;
         check("flush_len", cnt, W + 1);
         @(negedge clk); #1;
         check("win_count", got_q.size(), N);
      end
   endtask

   // Known windows of a frame whose pixels are b+1 .. b+N.
   task automatic check_seq(input int b);
      if (got_q.size() != N) begin
         check("seq_size", got_q.size(), N);
      end else begin
`ifdef SOBEL_WIN_REPLICATE_EN
         check("first_win", got_q[0], pk(b+1, b+1, b+2, b+1, b+1, b+2, b+5, b+5, b+6));
         check("last_win", got_q[N-1], pk(b+7, b+8, b+8, b+11, b+12, b+12, b+11, b+12, b+12));
`else
         check("first_win", got_q[0], pk(0, 0, 0, 0, b+1, b+2, 0, b+5, b+6));
         check("last_win", got_q[N-1], pk(b+7, b+8, 0, b+11, b+12, 0, 0, 0, 0));
`endif
         check("centre11_win", got_q[5], pk(b+1, b+2, b+3, b+5, b+6, b+7, b+9, b+10, b+11));
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_window", {p0, p1, p2, p3, p4, p5, p6, p7, p8}, 72'd0);
      rst_n = 1'b1;

      fill_seq(0);
      run_frame(0, N);
      check_seq(0);

      run_frame(1, N);
      check_seq(0);

      fill_seq(100);
      run_frame(0, N);
      check_seq(100);

      fill_seq(0);
      run_frame(0, 7);
      check("pre_rst_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_window", {p0, p1, p2, p3, p4, p5, p6, p7, p8}, 72'd0);
      check("arst_in_ready", in_ready, 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame(0, N);
      check_seq(0);

      for (int f = 0; f < 4; f++) begin
         fill_rand();
         run_frame(2, N);
      end
      fill_rand();
      run_frame(1, N);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule
